// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - Switch/controller-side bus of the program-feed sequencer
interface instr_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [9:0]    SW;
    logic          WRb;
    logic          STEPb;
    logic          MODE;
    logic          AUTO;
    logic          EXT;
    logic          DONE;
    logic [9:0]    DOUT;
    logic          STEPCLK;
    logic [AW-1:0] PC;
    logic [AW:0]   WP;
    logic          FULL;
    logic          HALT;

    modport master (
        output SW, WRb, STEPb, MODE, AUTO, EXT, DONE,
        input  DOUT, STEPCLK, PC, WP, FULL, HALT
    );

    modport slave (
        input  SW, WRb, STEPb, MODE, AUTO, EXT, DONE,
        output DOUT, STEPCLK, PC, WP, FULL, HALT
    );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - Program store/replay with processor step-clock generator
// SEQ_AUTORUN_EN adds a PERIOD-spaced auto-step source selected by AUTO.
module instr_sequencer #(
    parameter int DEPTH  = 16,
    parameter int PW     = 4,
    parameter int PERIOD = 25_000_000
) (
    input  logic             CLK50M,
    input  logic             RSTb,
    instr_sequencer_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(PW + 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] PW_LAST = CW'(PW - 1);

    typedef enum logic [2:0] {LOAD, RUN_IDLE, RUN_HI, RUN_LO, HALTED} stateT;

    stateT         state, stateNext;
    logic [1:0]    wrSync, stepSync, modeSync;
    logic          wrPrev, stepPrev, modePrev;
    logic          wrEvent, stepEvent, modeRise, trigger;
    logic [CW-1:0] cnt, cntNext;
    logic [AW:0]   pcInt, pcNext, wpReg, wpNext;
    logic          extQ, extQNext, haltQ, haltQNext;
    logic          wrEn;
    logic [9:0]    prog [DEPTH];
    logic [9:0]    dout;
    logic          stepClk, halt;

    // Buttons idle high, so their synchronizers reset to 1 to avoid a phantom press.
    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            wrSync   <= 2'b11;
            stepSync <= 2'b11;
            modeSync <= 2'b00;
            wrPrev   <= 1'b1;
            stepPrev <= 1'b1;
            modePrev <= 1'b0;
        end else begin
            wrSync   <= {wrSync[0], bus.WRb};
            stepSync <= {stepSync[0], bus.STEPb};
            modeSync <= {modeSync[0], bus.MODE};
            wrPrev   <= wrSync[1];
            stepPrev <= stepSync[1];
            modePrev <= modeSync[1];
        end
    end

    assign wrEvent   = wrPrev & ~wrSync[1];
    assign stepEvent = stepPrev & ~stepSync[1];
    assign modeRise  = modeSync[1] & ~modePrev;

`ifdef SEQ_AUTORUN_EN
    localparam int             PCW         = $clog2(PERIOD + 1);
    localparam logic [PCW-1:0] PERIOD_LAST = PCW'(PERIOD - 1);

    logic [1:0]     autoSync;
    logic [PCW-1:0] periodCnt;

    // Counts from each rising edge; parks at the terminal value so the first auto step is immediate.
    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            autoSync  <= 2'b00;
            periodCnt <= PERIOD_LAST;
        end else begin
            autoSync <= {autoSync[0], bus.AUTO};
            if (state == RUN_IDLE && stateNext == RUN_HI) begin
                periodCnt <= '0;
            end else if (!autoSync[1]) begin
                periodCnt <= PERIOD_LAST;
            end else if (periodCnt != PERIOD_LAST) begin
                periodCnt <= periodCnt + 1'b1;
            end
        end
    end

    assign trigger = autoSync[1] ? (periodCnt == PERIOD_LAST) : stepEvent;
`else
    localparam int unusedPeriod = PERIOD;
    logic unusedAuto;
    assign unusedAuto = bus.AUTO;
    assign trigger    = stepEvent;
`endif

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pcNext    = pcInt;
        wpNext    = wpReg;
        extQNext  = extQ;
        haltQNext = haltQ;
        wrEn      = 1'b0;
        unique case (state)
            LOAD: begin
                if (wrEvent && (wpReg < DEPTH_W)) begin
                    wrEn   = 1'b1;
                    wpNext = wpReg + 1'b1;
                end
                // RUN entry sees a write landing in the same cycle.
                if (modeRise) begin
                    pcNext    = '0;
                    stateNext = (wpNext == '0) ? HALTED : RUN_IDLE;
                end
            end
            RUN_IDLE: begin
                if (!modeSync[1]) begin
                    stateNext = LOAD;
                    wpNext    = '0;
                    pcNext    = '0;
                end else if (trigger) begin
                    stateNext = RUN_HI;
                    cntNext   = '0;
                    extQNext  = bus.EXT;
                    haltQNext = bus.DONE && (pcInt == wpReg);
                end
            end
            RUN_HI: begin
                if (cnt == PW_LAST) begin
                    cntNext = '0;
                    if (extQ && (pcInt < wpReg)) begin
                        pcNext = pcInt + 1'b1;
                    end
                    if (!modeSync[1]) begin
                        stateNext = LOAD;
                        wpNext    = '0;
                        pcNext    = '0;
                    end else begin
                        stateNext = RUN_LO;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            RUN_LO: begin
                if (!modeSync[1]) begin
                    stateNext = LOAD;
                    wpNext    = '0;
                    pcNext    = '0;
                end else if (cnt == PW_LAST) begin
                    stateNext = haltQ ? HALTED : RUN_IDLE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            HALTED: begin
                if (!modeSync[1]) begin
                    stateNext = LOAD;
                    wpNext    = '0;
                    pcNext    = '0;
                end
            end
            default: stateNext = LOAD;
        endcase
    end

    // STEPCLK and HALT are registered from the next state so they are glitch-free.
    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            state   <= LOAD;
            cnt     <= '0;
            pcInt   <= '0;
            wpReg   <= '0;
            extQ    <= 1'b0;
            haltQ   <= 1'b0;
            dout    <= '0;
            stepClk <= 1'b0;
            halt    <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            pcInt   <= pcNext;
            wpReg   <= wpNext;
            extQ    <= extQNext;
            haltQ   <= haltQNext;
            dout    <= (pcInt < wpReg) ? prog[pcInt[AW-1:0]] : '0;
            stepClk <= (stateNext == RUN_HI);
            halt    <= (stateNext == HALTED);
        end
    end

    always_ff @(posedge CLK50M) begin
        if (wrEn) begin
            prog[wpReg[AW-1:0]] <= bus.SW;
        end
    end

    assign bus.DOUT    = dout;
    assign bus.STEPCLK = stepClk;
    assign bus.PC      = pcInt[AW-1:0];
    assign bus.WP      = wpReg;
    assign bus.FULL    = (wpReg == DEPTH_W);
    assign bus.HALT    = halt;
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program-feed stage upstream of the 10-bit processor. It stores a short program of 10-bit words entered from the switches, then replays them. It generates the processor's step clock and presents the next program word on `DOUT` whenever the controller requests external data (`EXT`). The top level routes `DOUT` onto the bus in place of the raw switches and uses `STEPCLK` in place of the debounced clock button.

## Interface
- `DEPTH`, 16: program memory words (power of two).
- `PW`, 4: `STEPCLK` high time in `CLK50M` cycles (≥2).
- `PERIOD`, 25_000_000: auto-run cycles between step rising edges (> 2·`PW`).
- `CLK50M` in 1: system clock; all logic on its rising edge.
- `RSTb` in 1: asynchronous active-low reset.
- `SW` in 10: word to store.
- `WRb` in 1: debounced store button, active low.
- `STEPb` in 1: debounced manual step button, active low.
- `MODE` in 1: 0 = LOAD, 1 = RUN.
- `AUTO` in 1: auto-run select (only with `SEQ_AUTORUN_EN`).
- `EXT` in 1: controller requests external data this step.
- `DONE` in 1: controller's instruction-complete (`Clr`).
- `DOUT` out 10: `PROG[PC]`, registered.
- `STEPCLK` out 1: processor step clock.
- `PC` out log2(`DEPTH`): read pointer.
- `WP` out log2(`DEPTH`)+1: words loaded.
- `FULL` out 1: `WP == DEPTH`.
- `HALT` out 1: program exhausted.

## Operation
- States: LOAD, RUN_IDLE, RUN_HI, RUN_LO, HALTED.
- Reset: state = LOAD. `PC`=0, `WP`=0, `DOUT`=0, `STEPCLK`=0, `HALT`=0, `FULL`=0. Memory contents are not reset.
- `WRb`, `STEPb`, `MODE`, `AUTO` pass through 2-flop synchronizers. Button events are detected on the synchronized falling edge: one event per press.
- LOAD:
  - Write event with `WP < DEPTH` → `PROG[WP] <= SW`, `WP++`.
  - Write event with `WP == DEPTH` → ignored, `FULL` stays 1.
  - `STEPb` events are ignored.
- LOAD → RUN on `MODE` rising: `PC`=0. If `WP==0` → HALTED, else → RUN_IDLE.
- RUN_IDLE: a step trigger → RUN_HI, `STEPCLK`=1, and `EXT` is captured into `ext_q`.
- RUN_HI: holds for `PW` cycles → RUN_LO, `STEPCLK`=0. On that same cycle, if `ext_q`, `PC++`.
- RUN_LO: holds `PW` cycles → RUN_IDLE.
- Halt: if `DONE` is high at the capture cycle and `PC == WP`, the pulse completes and the state goes → HALTED instead of RUN_IDLE.
- `PC` never exceeds `WP`. An `EXT` request with `PC == WP` still pulses, but `PC` holds and `DOUT` = 0.
- HALTED: `HALT`=1, `STEPCLK`=0, step triggers are ignored.
- `MODE` falling in any RUN state or HALTED:
  - If `STEPCLK` is high, finish RUN_HI first (no runt pulse). Otherwise go immediately.
  - Then → LOAD with `WP`=0, `PC`=0, `HALT`=0. The program is overwritten by new writes.
- `DOUT` is updated one cycle after `PC` or `WP` changes. It is stable throughout each `STEPCLK` high and the following falling edge.

## Timing
- Write event → `WP`/`FULL` update: 3 cycles after the `WRb` pin falls (2 sync + 1).
- Manual step: `STEPCLK` rises 3 cycles after the `STEPb` pin falls.
- Pulse shape: high exactly `PW` cycles, minimum low `PW` cycles.
- `PC` increments coincident with `STEPCLK` falling. `DOUT` settles 1 cycle later, which is ≥`PW`−1 cycles before the next rising edge.
- Simultaneous write event and `MODE` rising: the write is applied first, then RUN entry uses the updated `WP`.
- A step trigger arriving during RUN_HI/RUN_LO is dropped, not queued.
- Reset asserted mid-pulse: `STEPCLK` drops immediately, asynchronously.

## Configuration
- `SEQ_AUTORUN_EN` defined: in RUN_IDLE, synchronized `AUTO`=1 issues a step trigger every `PERIOD` cycles, measured rising edge to rising edge. Manual `STEPb` still works when `AUTO`=0.
- `SEQ_AUTORUN_EN` undefined: no period counter, `AUTO` is ignored, steps come only from `STEPb`.

## Test plan
- Load and replay:
  - Reset, write `SW`=0x0C1 then 0x2A5 → `WP`=2, `FULL`=0.
  - Set `MODE`=1, `DOUT`=0x0C1.
  - Step with `EXT`=1 → `PC`=1 on `STEPCLK` fall, `DOUT`=0x2A5 next cycle.
- Fill and overflow: 17 writes with `DEPTH`=16 → `WP`=16, `FULL`=1. `PROG[15]` holds the 16th word, the 17th is dropped.
- No advance on `EXT`=0: step with `EXT`=0 → pulse high 4 cycles, `PC` unchanged.
- Halt and empty program:
  - `WP`=1; step with `EXT`=1, then step with `DONE`=1 → `HALT`=1; further `STEPb` presses produce no pulse.
  - `MODE`=1 with `WP`=0 → `HALT`=1 immediately.
- Abort mid-pulse: `MODE`→0 during RUN_HI → pulse completes its full 4 cycles, then LOAD with `WP`=0, `PC`=0.
- Auto-run (macro on, `PERIOD`=20, `PW`=4): `AUTO`=1 → rising edges exactly 20 cycles apart. Reset asserted mid-high → `STEPCLK`=0 same cycle, all outputs at reset values.
